// File: rtl/core_pkg.sv
// Shared core types: datapath width, address/instruction words and the fetch queue entry.
package core_pkg;
    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [31:0]     inst_t;

    localparam addr_t RESET_PC_DEFAULT = '0;
    localparam inst_t NOP              = 32'h0000_0013;

    typedef struct packed {
        addr_t pc;
        inst_t instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of T with push/pop/flush; head visible the cycle after push.
// Push while full is only honoured alongside a pop; pop while empty is ignored.
module fetch_queue
    import core_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  T                      push_dat_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output T                      head_o
);
    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW:0]    count_q;
    logic           do_pop;
    logic           do_push;

    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != (AW+1)'(DEPTH)) | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: credit-limited in-order imem requests, queued (pc, instr) to decode.
// Response-to-if_valid is one registered cycle; redirect flushes the queue and drops in-flight responses.
module fetch_stage
    import core_pkg::*;
#(
    parameter addr_t RESET_PC    = RESET_PC_DEFAULT,
    parameter int    QUEUE_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    addr_t         pc_q, pc_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] inflight, inflight_d;
    logic [CW-1:0] q_count;
    logic [CW:0]   occupancy;
    logic          deq, req_fire, resp_ok, resp_drop;
    addr_t         tag_pc;
    fetch_entry_t  q_push_dat, q_head;

    // The tag FIFO holds exactly one entry per outstanding request, so its count is the inflight count.
    assign deq            = if_valid & if_ready;
    assign occupancy      = {1'b0, q_count} + {1'b0, inflight} - {{CW{1'b0}}, deq};
    assign imem_req_valid = rst & ~redirect_valid & (occupancy < (CW+1)'(QUEUE_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign resp_ok        = imem_resp_valid & (inflight != '0);
    assign resp_drop      = resp_ok & (drop_q != '0);
    assign inflight_d     = inflight + CW'(req_fire) - CW'(resp_ok);
    assign if_valid       = (q_count != '0) & ~redirect_valid;
    assign q_push_dat     = '{pc: tag_pc, instr: imem_resp_data};
    assign if_pc          = q_head.pc;
    assign if_instr       = q_head.instr;

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc & ~addr_t'(3);
            drop_d = inflight_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + addr_t'(4);
            end
            if (resp_drop) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH), .T(fetch_entry_t)) u_inst_q (
        .clk        (clk),
        .rst        (rst),
        .push_i     (resp_ok & ~resp_drop),
        .push_dat_i (q_push_dat),
        .pop_i      (deq),
        .flush_i    (redirect_valid),
        .count_o    (q_count),
        .head_o     (q_head)
    );

    fetch_queue #(.DEPTH(QUEUE_DEPTH), .T(addr_t)) u_tag_q (
        .clk        (clk),
        .rst        (rst),
        .push_i     (req_fire),
        .push_dat_i (pc_q),
        .pop_i      (resp_ok),
        .flush_i    (1'b0),
        .count_o    (inflight),
        .head_o     (tag_pc)
    );

    resp_needs_request: assert property (@(posedge clk) disable iff (!rst)
        imem_resp_valid |-> (inflight != '0));
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined core, instantiated inside Top.core.
- Feeds the decode stage.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready bus.
- Buffers returned instructions in a small queue and hands (pc, instr) to decode with a valid/ready handshake.
- On a branch/jump redirect from execute, flushes the queue and discards stale in-flight responses.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QUEUE_DEPTH, 4, fetch-queue entries; must be ≥2 and a power of two.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- imem_req_valid  out  1  fetch request present.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address (current PC).
- imem_resp_valid  in  1  response data valid; responses return in request order, latency ≥1 cycle.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  execute requests a PC change.
- redirect_pc  in  XLEN  new PC; bits [1:0] are ignored and forced to 0.
- if_valid  out  1  decode-side instruction available.
- if_ready  in  1  decode accepts.
- if_pc  out  XLEN  PC of the presented instruction.
- if_instr  out  32  presented instruction.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; queue empty; inflight=0; drop=0.
  - imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0.
- First request: imem_req_valid rises in the first cycle after rst deasserts.
- Credit rule: imem_req_valid = ~redirect_valid & (count + inflight − deq < QUEUE_DEPTH).
  - deq = if_valid & if_ready in the current cycle.
- Request accepted (imem_req_valid & imem_req_ready): pc += 4 (wraps modulo 2^XLEN); inflight += 1.
- Response arrival (imem_resp_valid):
  - inflight −= 1.
  - If drop>0: drop −= 1 and the data is discarded.
  - Otherwise push {pc_tag, data} into the queue. pc_tag comes from a tag FIFO of accepted request addresses, which has the same depth as the credit.
  - Response with inflight=0 is a protocol error: assertion fails, state unchanged.
- Queue behaviour:
  - No response-to-output bypass: an instruction becomes visible on if_* the cycle after its response.
  - Minimum latency from req accept to if_valid is therefore 2 cycles at 1-cycle memory latency.
  - Push and pop in the same cycle are legal, including when the queue is full or empty (the credit rule guarantees no overflow).
- Output:
  - if_valid = (count≠0) & ~redirect_valid.
  - if_pc/if_instr = queue head; they hold steady while if_valid & ~if_ready.
- Redirect (redirect_valid=1), priority over everything else:
  - Next cycle: pc=redirect_pc & ~3; queue count=0.
  - drop = inflight_next, i.e. all outstanding requests, excluding any response consumed this cycle.
  - No request issued and no dequeue in the redirect cycle.
  - Fetch resumes at redirect_pc on the following cycle.
- Back-to-back redirects: the last one wins; drop accumulates correctly.
- Throughput: with 1-cycle memory, always-ready decode and QUEUE_DEPTH≥2, sustains 1 instruction/cycle.
- Reset mid-operation: all counters and the queue are cleared immediately. Memory responses to pre-reset requests are the memory's responsibility (memory shares the same reset).

Decomposition:
- core_pkg holds:
  - XLEN, addr_t, inst_t, the RESET_PC default, NOP constant 32'h0000_0013.
  - fetch_entry_t {addr_t pc; inst_t instr}.
- One sub-module, fetch_queue:
  - Parameterised sync FIFO of fetch_entry_t with push, pop, flush, count, head.
  - Instantiated twice: instruction queue and request-address tag FIFO (tag FIFO is not flushed; it pops on every response).

Test Plan:
- Reset, 1-cycle memory returning addr-as-data, if_ready=1 → req addrs 0,4,8,… on consecutive cycles; if_pc/if_instr = 0/0 three cycles after rst release, then +4 each cycle.
- if_ready=0 for 10 cycles → at most QUEUE_DEPTH(4) requests outstanding plus queued; imem_req_valid=0 thereafter; if_pc held at 0; after release, order 0,4,8,12 with no loss.
- 3-cycle memory latency, redirect_pc=0x100 while 3 requests are in flight → 3 responses dropped; next if_pc=0x100; no if_valid in the redirect cycle.
- Redirect with redirect_pc=0x203 → next imem_req_addr=0x200.
- Two redirects on consecutive cycles (0x40 then 0x80) → first delivered if_pc=0x80; nothing from 0x40 is delivered.
- Assert rst=0 mid-stream while the queue is full → next cycle if_valid=0, imem_req_valid=0; after release, fetch restarts at RESET_PC.
